// File: rtl/display_scan_if.sv
// Bus between the stopwatch counter chain / board pins and display_scan_mux.
// The counter side drives enable/digits/dp_mask; the display pins are returned.
interface display_scan_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIGIT_BITS = 4
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                             enable;
    logic [NUM_DIGITS*DIGIT_BITS-1:0] digits;
    logic [NUM_DIGITS-1:0]            dp_mask;
    logic [NUM_DIGITS-1:0]            an;
    logic [6:0]                       seg;
    logic                             dp;
    logic [IDX_W-1:0]                 scan_index;
    logic                             frame_tick;

    modport master (
        output enable, digits, dp_mask,
        input  an, seg, dp, scan_index, frame_tick
    );

    modport slave (
        input  enable, digits, dp_mask,
        output an, seg, dp, scan_index, frame_tick
    );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with per-frame digit snapshot.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZ_BLANK_EN.
module display_scan_mux #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIGIT_BITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input logic           clk,
    input logic           rst_n,
    display_scan_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0]      PRE_BLANK = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = 7'b1111111;
    localparam logic [6:0]            SEG_DASH  = 7'b0111111;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = '1;

    // Active-low {g,f,e,d,c,b,a}; anything above 9 renders as a dash.
    function automatic logic [6:0] seg_decode(input logic [DIGIT_BITS-1:0] v);
        logic [6:0] s;
        s = SEG_DASH;
        case (32'(v))
            0: s = 7'b1000000;
            1: s = 7'b1111001;
            2: s = 7'b0100100;
            3: s = 7'b0110000;
            4: s = 7'b0011001;
            5: s = 7'b0010010;
            6: s = 7'b0000010;
            7: s = 7'b1111000;
            8: s = 7'b0000000;
            9: s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIGIT_BITS-1:0] snap_q [NUM_DIGITS];
    logic [DIGIT_BITS-1:0] snap_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dps_q, dps_d;
    logic                  load_pend_q, load_pend_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [IDX_W-1:0]      sidx_q, sidx_d;
    logic                  ftick_q, ftick_d;
    logic                  load_c;

`ifdef DISPLAY_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_q, lz_d, lz_new_c;

    // Blank mask for the value about to be captured; digit 0 always shows.
    always_comb begin
        logic lead;
        lead     = 1'b1;
        lz_new_c = '0;
        for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
            if (lead && (bus.digits[k*DIGIT_BITS +: DIGIT_BITS] == '0) && !bus.dp_mask[k]) begin
                lz_new_c[k] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
    end
`endif

    // Scan sequencing, snapshot capture and registered pin values.
    always_comb begin
        pre_d       = pre_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        dps_d       = dps_q;
        load_pend_d = load_pend_q;
        an_d        = AN_OFF;
        seg_d       = SEG_OFF;
        dp_d        = 1'b1;
        sidx_d      = '0;
        ftick_d     = 1'b0;
        load_c      = 1'b0;
`ifdef DISPLAY_LZ_BLANK_EN
        lz_d        = lz_q;
`endif

        if (!bus.enable) begin
            pre_d       = '0;
            idx_d       = '0;
            load_pend_d = 1'b1;
        end else begin
            sidx_d = idx_q;
            if (!load_pend_q && (pre_q >= PRE_BLANK)) begin
                an_d[idx_q] = 1'b0;
                seg_d       = seg_decode(snap_q[idx_q]);
`ifdef DISPLAY_LZ_BLANK_EN
                if (lz_q[idx_q]) begin
                    seg_d = SEG_OFF;
                end
`endif
                dp_d = ~dps_q[idx_q];
            end

            // A pending load behaves like the frame-wrap boundary so every frame is full length.
            if (load_pend_q) begin
                pre_d  = '0;
                idx_d  = '0;
                load_c = 1'b1;
            end else if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d  = '0;
                    load_c = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end

            if (load_c) begin
                for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                    snap_d[k] = bus.digits[k*DIGIT_BITS +: DIGIT_BITS];
                end
                dps_d       = bus.dp_mask;
                ftick_d     = 1'b1;
                load_pend_d = 1'b0;
`ifdef DISPLAY_LZ_BLANK_EN
                lz_d        = lz_new_c;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            idx_q       <= '0;
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                snap_q[k] <= '0;
            end
            dps_q       <= '0;
            load_pend_q <= 1'b1;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            sidx_q      <= '0;
            ftick_q     <= 1'b0;
`ifdef DISPLAY_LZ_BLANK_EN
            lz_q        <= '0;
`endif
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            dps_q       <= dps_d;
            load_pend_q <= load_pend_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            sidx_q      <= sidx_d;
            ftick_q     <= ftick_d;
`ifdef DISPLAY_LZ_BLANK_EN
            lz_q        <= lz_d;
`endif
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.scan_index = sidx_q;
    assign bus.frame_tick = ftick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with a 4-digit, 4-cycle-slot, 1-cycle-blank setup.
module tb_display_scan_mux;
    localparam int unsigned ND = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 4;
    localparam int unsigned BC = 1;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SX = 7'b1111111;
`ifdef DISPLAY_LZ_BLANK_EN
    localparam logic [6:0] LZ0 = SX;
`else
    localparam logic [6:0] LZ0 = S0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    display_scan_if #(.NUM_DIGITS(ND), .DIGIT_BITS(DB)) bus ();

    display_scan_mux #(
        .NUM_DIGITS(ND), .DIGIT_BITS(DB), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ea, input logic [6:0] es,
                           input logic ed, input logic [1:0] ei, input logic ef);
        chk({tag, ".an"},   32'(bus.an),         32'(ea));
        chk({tag, ".seg"},  32'(bus.seg),        32'(es));
        chk({tag, ".dp"},   32'(bus.dp),         32'(ed));
        chk({tag, ".idx"},  32'(bus.scan_index), 32'(ei));
        chk({tag, ".tick"}, 32'(bus.frame_tick), 32'(ef));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One digit slot: one blank cycle then three lit cycles; tick on the final cycle of slot 3.
    task automatic run_slot(input string tag, input int s, input logic [6:0] sg,
                            input logic dpn, input logic last);
        logic [3:0] ea;
        ea = 4'hF;
        ea[2'(s)] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 0)
                chk_out($sformatf("%s.s%0d.c%0d", tag, s, c), 4'hF, SX, 1'b1, 2'(s), 1'b0);
            else
                chk_out($sformatf("%s.s%0d.c%0d", tag, s, c), ea, sg, dpn, 2'(s),
                        last && (c == 3));
        end
    endtask

    task automatic run_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn);
        run_slot(tag, 0, s0, dpn[0], 1'b0);
        run_slot(tag, 1, s1, dpn[1], 1'b0);
        run_slot(tag, 2, s2, dpn[2], 1'b0);
        run_slot(tag, 3, s3, dpn[3], 1'b1);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.enable     = 1'b0;
        bus.digits     = '0;
        bus.dp_mask    = '0;
        #12;
        chk_out("reset", 4'hF, SX, 1'b1, 2'd0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_out("idle", 4'hF, SX, 1'b1, 2'd0, 1'b0);

        // First enabled edge captures the snapshot.
        bus.digits = 16'h1234;
        bus.enable = 1'b1;
        tick();
        chk_out("first", 4'hF, SX, 1'b1, 2'd0, 1'b1);
        run_frame("f1", S4, S3, S2, S1, 4'hF);

        // Digits change mid-frame: rest of the frame keeps the old snapshot.
        run_slot("f2", 0, S4, 1'b1, 1'b0);
        bus.digits = 16'h5678;
        run_slot("f2", 1, S3, 1'b1, 1'b0);
        run_slot("f2", 2, S2, 1'b1, 1'b0);
        run_slot("f2", 3, S1, 1'b1, 1'b1);

        run_slot("f3", 0, S8, 1'b1, 1'b0);
        bus.digits  = 16'h00A0;
        bus.dp_mask = 4'b0010;
        run_slot("f3", 1, S7, 1'b1, 1'b0);
        run_slot("f3", 2, S6, 1'b1, 1'b0);
        run_slot("f3", 3, S5, 1'b1, 1'b1);

        // Dash with decimal point; leading zeros above it.
        run_slot("f4", 0, S0, 1'b1, 1'b0);
        bus.digits  = 16'h0000;
        bus.dp_mask = 4'b0000;
        run_slot("f4", 1, SD, 1'b0, 1'b0);
        run_slot("f4", 2, LZ0, 1'b1, 1'b0);
        run_slot("f4", 3, LZ0, 1'b1, 1'b1);

        run_frame("f5", S0, LZ0, LZ0, LZ0, 4'hF);

        // Drop enable while idx=2 and pre=2.
        run_slot("f6", 0, S0, 1'b1, 1'b0);
        run_slot("f6", 1, LZ0, 1'b1, 1'b0);
        tick();
        chk_out("f6.s2.c0", 4'hF, SX, 1'b1, 2'd2, 1'b0);
        tick();
        chk_out("f6.s2.c1", 4'b1011, LZ0, 1'b1, 2'd2, 1'b0);
        bus.enable = 1'b0;
        tick();
        chk_out("dis0", 4'hF, SX, 1'b1, 2'd0, 1'b0);
        tick();
        chk_out("dis1", 4'hF, SX, 1'b1, 2'd0, 1'b0);

        bus.digits  = 16'h1234;
        bus.dp_mask = 4'b0001;
        bus.enable  = 1'b1;
        tick();
        chk_out("reen", 4'hF, SX, 1'b1, 2'd0, 1'b1);
        run_frame("f7", S4, S3, S2, S1, 4'b1110);

        // Asynchronous reset in the middle of a lit cycle.
        run_slot("f8", 0, S4, 1'b0, 1'b0);
        tick();
        chk_out("f8.s1.c0", 4'hF, SX, 1'b1, 2'd1, 1'b0);
        tick();
        chk_out("f8.s1.c1", 4'b1101, S3, 1'b1, 2'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 4'hF, SX, 1'b1, 2'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("post_rst", 4'hF, SX, 1'b1, 2'd0, 1'b1);
        run_slot("f9", 0, S4, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
